// File: rtl/seg_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : seg_pkg
//  Description : Shared segment encodings, segment bit-order type and scan
//                timing helper for the seven-segment scan driver.
//  Revision    : 1.0 - initial release
// ============================================================================
package seg_pkg;

  // Segment bit order on every 7-bit segment bus: {g,f,e,d,c,b,a}
  typedef struct packed {
    logic g;
    logic f;
    logic e;
    logic d;
    logic c;
    logic b;
    logic a;
  } seg7_t;

  localparam int SEG_W = 7;

  // Active-high segment patterns, bit order {g,f,e,d,c,b,a}
  localparam logic [SEG_W-1:0] SEG_0     = 7'b0111111;
  localparam logic [SEG_W-1:0] SEG_1     = 7'b0000110;
  localparam logic [SEG_W-1:0] SEG_2     = 7'b1011011;
  localparam logic [SEG_W-1:0] SEG_3     = 7'b1001111;
  localparam logic [SEG_W-1:0] SEG_4     = 7'b1100110;
  localparam logic [SEG_W-1:0] SEG_5     = 7'b1101101;
  localparam logic [SEG_W-1:0] SEG_6     = 7'b1111101;
  localparam logic [SEG_W-1:0] SEG_7     = 7'b0000111;
  localparam logic [SEG_W-1:0] SEG_8     = 7'b1111111;
  localparam logic [SEG_W-1:0] SEG_9     = 7'b1101111;
  localparam logic [SEG_W-1:0] SEG_BLANK = 7'b0000000;

  // Number of clock cycles in one digit slot
  function automatic int slot_count(input int scan_log2);
    return 1 << scan_log2;
  endfunction

endpackage
`default_nettype wire

// File: rtl/seg7_decode.sv
`default_nettype none
// ============================================================================
//  Module      : seg7_decode
//  Description : Combinational BCD to seven-segment decoder. Codes 10..15
//                decode to an unlit digit.
//  Revision    : 1.0 - initial release
// ============================================================================
module seg7_decode
  import seg_pkg::*;
(
  input  logic [3:0]       bcd,
  output logic [SEG_W-1:0] seg
);

  // BCD lookup; non-decimal codes fall through to blank
  always_comb begin
    seg = SEG_BLANK;
    case (bcd)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/seg_scan_driver.sv
`default_nettype none
// ============================================================================
//  Module      : seg_scan_driver
//  Description : Time-multiplexed seven-segment scan driver. One digit per
//                slot of 2^SCAN_LOG2 cycles, slot 0 is a dark dead cycle,
//                PWM brightness gating, per-digit blink, frame-start input
//                shadowing and fully registered outputs.
//                Optional build macro SEG_LEAD_ZERO_BLANK_EN enables
//                leading-zero suppression evaluated at shadow load.
//  Revision    : 1.0 - initial release
// ============================================================================
module seg_scan_driver
  import seg_pkg::*;
#(
  parameter int NUM_DIGITS   = 6,   // 2..8
  parameter int SCAN_LOG2    = 4,
  parameter int PWM_BITS     = 3,   // must not exceed SCAN_LOG2-1
  parameter int BLINK_FRAMES = 64   // >= 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [4*NUM_DIGITS-1:0] digit_bcd,
  input  logic [NUM_DIGITS-1:0]   blink_mask,
  input  logic [PWM_BITS-1:0]     brightness,
  input  logic                    colon_in,
  output logic [SEG_W-1:0]        seg_out,
  output logic [NUM_DIGITS-1:0]   dig_sel,
  output logic                    colon_out,
  output logic                    frame_done
);

  localparam int IDX_W = $clog2(NUM_DIGITS);
  localparam int BC_W  = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  localparam logic [SCAN_LOG2-1:0] SLOT_LAST  = SCAN_LOG2'(slot_count(SCAN_LOG2) - 1);
  localparam logic [IDX_W-1:0]     IDX_LAST   = IDX_W'(NUM_DIGITS - 1);
  localparam logic [BC_W-1:0]      BLINK_LAST = BC_W'(BLINK_FRAMES - 1);

  // Scan and blink counters
  logic [SCAN_LOG2-1:0] slot_cnt_q, slot_cnt_d;
  logic [IDX_W-1:0]     dig_idx_q, dig_idx_d;
  logic [BC_W-1:0]      blink_cnt_q, blink_cnt_d;
  logic                 blink_phase_q, blink_phase_d;

  // Frame-start shadows of the inputs
  logic [4*NUM_DIGITS-1:0] sh_bcd_q, sh_bcd_d;
  logic [NUM_DIGITS-1:0]   sh_blink_q, sh_blink_d;
  logic [PWM_BITS-1:0]     sh_bright_q, sh_bright_d;
  logic                    sh_colon_q, sh_colon_d;

  // Registered outputs
  logic [SEG_W-1:0]      seg_out_q, seg_out_d;
  logic [NUM_DIGITS-1:0] dig_sel_q, dig_sel_d;
  logic                  colon_out_q, colon_out_d;
  logic                  frame_done_q, frame_done_d;

  // Combinational helpers
  logic       w_slot_wrap;
  logic       w_frame_wrap;
  logic       w_frame_start;
  logic       w_lit;
  logic       w_blank;
  logic [3:0] w_cur_bcd;
  seg7_t      w_dec_seg;

  assign w_slot_wrap   = (slot_cnt_q == SLOT_LAST);
  assign w_frame_wrap  = w_slot_wrap && (dig_idx_q == IDX_LAST);
  assign w_frame_start = (slot_cnt_q == '0) && (dig_idx_q == '0);

  // PWM gate: the top PWM_BITS of the slot counter form a ramp compared to
  // the duty level; slot 0 stays dark so the previous digit cannot ghost.
  assign w_lit = (slot_cnt_q != '0) &&
                 (slot_cnt_q[SCAN_LOG2-1 -: PWM_BITS] <= sh_bright_q);

  assign w_cur_bcd = sh_bcd_q[{dig_idx_q, 2'b00} +: 4];

  seg7_decode u_seg7_decode (
    .bcd (w_cur_bcd),
    .seg (w_dec_seg)
  );

`ifdef SEG_LEAD_ZERO_BLANK_EN
  logic [NUM_DIGITS-1:0] sh_lzb_q, sh_lzb_d;
  logic [NUM_DIGITS-1:0] w_lzb_mask;
  logic                  w_lz_seen;

  // Walk from the most significant digit down; zeros are blanked until the
  // first nonzero digit. Digit 0 always shows so a value of zero reads "0".
  always_comb begin
    w_lzb_mask = '0;
    w_lz_seen  = 1'b0;
    for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
      if (digit_bcd[4*i +: 4] != 4'd0) begin
        w_lz_seen = 1'b1;
      end
      w_lzb_mask[i] = ~w_lz_seen;
    end
  end

  // Leading-zero mask is shadowed alongside the digits it describes
  always_ff @(posedge clk) begin
    if (rst) begin
      sh_lzb_q <= '0;
    end else begin
      sh_lzb_q <= sh_lzb_d;
    end
  end

  // Reload the mask only at frame start
  always_comb begin
    sh_lzb_d = sh_lzb_q;
    if (w_frame_start) begin
      sh_lzb_d = w_lzb_mask;
    end
  end

  assign w_blank = (blink_phase_q && sh_blink_q[dig_idx_q]) || sh_lzb_q[dig_idx_q];
`else
  assign w_blank = blink_phase_q && sh_blink_q[dig_idx_q];
`endif

  // Next-state logic for counters, shadows and registered outputs
  always_comb begin
    slot_cnt_d    = slot_cnt_q + SCAN_LOG2'(1);
    dig_idx_d     = dig_idx_q;
    blink_cnt_d   = blink_cnt_q;
    blink_phase_d = blink_phase_q;
    sh_bcd_d      = sh_bcd_q;
    sh_blink_d    = sh_blink_q;
    sh_bright_d   = sh_bright_q;
    sh_colon_d    = sh_colon_q;

    if (w_slot_wrap) begin
      slot_cnt_d = '0;
      dig_idx_d  = (dig_idx_q == IDX_LAST) ? '0 : dig_idx_q + IDX_W'(1);
    end

    // Blink phase flips on the frame wrap so the whole next frame sees it
    if (w_frame_wrap) begin
      if (blink_cnt_q == BLINK_LAST) begin
        blink_cnt_d   = '0;
        blink_phase_d = ~blink_phase_q;
      end else begin
        blink_cnt_d = blink_cnt_q + BC_W'(1);
      end
    end

    // Capture a coherent snapshot so a frame never shows torn data
    if (w_frame_start) begin
      sh_bcd_d    = digit_bcd;
      sh_blink_d  = blink_mask;
      sh_bright_d = brightness;
      sh_colon_d  = colon_in;
    end

    seg_out_d    = (w_lit && !w_blank) ? w_dec_seg : SEG_BLANK;
    dig_sel_d    = w_lit ? (NUM_DIGITS'(1) << dig_idx_q) : '0;
    colon_out_d  = w_lit && sh_colon_q;
    frame_done_d = w_frame_wrap;
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      slot_cnt_q    <= '0;
      dig_idx_q     <= '0;
      blink_cnt_q   <= '0;
      blink_phase_q <= 1'b0;
      sh_bcd_q      <= '0;
      sh_blink_q    <= '0;
      sh_bright_q   <= '0;
      sh_colon_q    <= 1'b0;
      seg_out_q     <= '0;
      dig_sel_q     <= '0;
      colon_out_q   <= 1'b0;
      frame_done_q  <= 1'b0;
    end else begin
      slot_cnt_q    <= slot_cnt_d;
      dig_idx_q     <= dig_idx_d;
      blink_cnt_q   <= blink_cnt_d;
      blink_phase_q <= blink_phase_d;
      sh_bcd_q      <= sh_bcd_d;
      sh_blink_q    <= sh_blink_d;
      sh_bright_q   <= sh_bright_d;
      sh_colon_q    <= sh_colon_d;
      seg_out_q     <= seg_out_d;
      dig_sel_q     <= dig_sel_d;
      colon_out_q   <= colon_out_d;
      frame_done_q  <= frame_done_d;
    end
  end

  assign seg_out    = seg_out_q;
  assign dig_sel    = dig_sel_q;
  assign colon_out  = colon_out_q;
  assign frame_done = frame_done_q;

endmodule
`default_nettype wire

// File: tb/tb_seg_scan_driver.sv
`default_nettype none
// ============================================================================
//  Module      : tb_seg_scan_driver
//  Description : Scoreboard bench for seg_scan_driver. A time-based reference
//                model predicts every registered output cycle; a monitor
//                compares the DUT against the queued predictions.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_seg_scan_driver;

  localparam int NUM_DIGITS   = 6;
  localparam int SCAN_LOG2    = 4;
  localparam int PWM_BITS     = 3;
  localparam int BLINK_FRAMES = 2;
  localparam int SLOT_LEN     = 1 << SCAN_LOG2;
  localparam int FRAME_LEN    = NUM_DIGITS * SLOT_LEN;

`ifdef SEG_LEAD_ZERO_BLANK_EN
  localparam bit LZ_EN = 1'b1;
`else
  localparam bit LZ_EN = 1'b0;
`endif

  logic                    clk;
  logic                    rst;
  logic [4*NUM_DIGITS-1:0] digit_bcd;
  logic [NUM_DIGITS-1:0]   blink_mask;
  logic [PWM_BITS-1:0]     brightness;
  logic                    colon_in;
  logic [6:0]              seg_out;
  logic [NUM_DIGITS-1:0]   dig_sel;
  logic                    colon_out;
  logic                    frame_done;

  seg_scan_driver #(
    .NUM_DIGITS   (NUM_DIGITS),
    .SCAN_LOG2    (SCAN_LOG2),
    .PWM_BITS     (PWM_BITS),
    .BLINK_FRAMES (BLINK_FRAMES)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .digit_bcd  (digit_bcd),
    .blink_mask (blink_mask),
    .brightness (brightness),
    .colon_in   (colon_in),
    .seg_out    (seg_out),
    .dig_sel    (dig_sel),
    .colon_out  (colon_out),
    .frame_done (frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [6:0]            seg;
    logic [NUM_DIGITS-1:0] dig;
    logic                  colon;
    logic                  fd;
  } obs_t;

  obs_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   k      = 0;   // index of the scan state in the current cycle since reset release

  // Inputs as they were at the most recent frame start
  logic [4*NUM_DIGITS-1:0] snap_bcd;
  logic [NUM_DIGITS-1:0]   snap_blink;
  logic [PWM_BITS-1:0]     snap_bright;
  logic                    snap_colon;

  function automatic logic [6:0] seg_of(input int v);
    case (v)
      0: return 7'b0111111;
      1: return 7'b0000110;
      2: return 7'b1011011;
      3: return 7'b1001111;
      4: return 7'b1100110;
      5: return 7'b1101101;
      6: return 7'b1111101;
      7: return 7'b0000111;
      8: return 7'b1111111;
      9: return 7'b1101111;
      default: return 7'b0000000;
    endcase
  endfunction

  function automatic int nibble(input logic [4*NUM_DIGITS-1:0] v, input int d);
    return int'((v >> (4 * d)) & 'hF);
  endfunction

  // Digit d is a leading zero when it and every digit above it are zero
  function automatic bit lead_blank(input logic [4*NUM_DIGITS-1:0] v, input int d);
    if (d == 0) return 1'b0;
    for (int j = d; j < NUM_DIGITS; j++) begin
      if (nibble(v, j) != 0) return 1'b0;
    end
    return 1'b1;
  endfunction

  // Expected outputs registered from scan state number kk
  function automatic obs_t expect_at(input int kk);
    obs_t o;
    int   slot  = kk % SLOT_LEN;
    int   d     = (kk / SLOT_LEN) % NUM_DIGITS;
    int   frame = kk / FRAME_LEN;
    bit   on    = (slot != 0) && ((slot >> (SCAN_LOG2 - PWM_BITS)) <= int'(snap_bright));
    bit   blank = (snap_blink[d] && (((frame / BLINK_FRAMES) % 2) == 1)) ||
                  (LZ_EN && lead_blank(snap_bcd, d));
    o = '0;
    if (on) begin
      o.dig   = NUM_DIGITS'(1 << d);
      o.colon = snap_colon;
      if (!blank) o.seg = seg_of(nibble(snap_bcd, d));
    end
    o.fd = ((kk % FRAME_LEN) == FRAME_LEN - 1);
    return o;
  endfunction

  // Reference model: one prediction per clock edge
  initial begin
    forever begin
      @(posedge clk);
      if (rst) begin
        k = 0;
        exp_q.push_back('0);
      end else begin
        if ((k % FRAME_LEN) == 0) begin
          snap_bcd    = digit_bcd;
          snap_blink  = blink_mask;
          snap_bright = brightness;
          snap_colon  = colon_in;
        end
        exp_q.push_back(expect_at(k));
        k++;
      end
    end
  end

  // Monitor: compare registered outputs shortly after each edge
  initial begin
    obs_t e;
    obs_t a;
    forever begin
      @(posedge clk);
      #1;
      a.seg   = seg_out;
      a.dig   = dig_sel;
      a.colon = colon_out;
      a.fd    = frame_done;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL scoreboard_empty t=%0t got seg=%b dig=%b colon=%b fd=%b, no expectation queued",
                 $time, a.seg, a.dig, a.colon, a.fd);
      end else begin
        e = exp_q.pop_front();
        if (a !== e) begin
          errors++;
          $display("FAIL outputs t=%0t got seg=%b dig=%b colon=%b fd=%b expected seg=%b dig=%b colon=%b fd=%b",
                   $time, a.seg, a.dig, a.colon, a.fd, e.seg, e.dig, e.colon, e.fd);
        end
      end
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Align to the negedge of the cycle whose scan state index within the frame is pos
  task automatic wait_state(input int pos);
    int n = 0;
    while ((k % FRAME_LEN) != pos) begin
      @(negedge clk);
      n++;
      if (n > 2 * FRAME_LEN) begin
        $display("FAIL wait_state got k=%0d expected frame position %0d", k, pos);
        $fatal(1, "stimulus alignment lost");
      end
    end
  endtask

  // Stimulus
  initial begin
    int sh;
    rst        = 1'b1;
    digit_bcd  = 24'h123456;
    blink_mask = '0;
    brightness = 3'd7;
    colon_in   = 1'b1;
    cycles(2);
    rst = 1'b0;
    cycles(2 * FRAME_LEN);

    brightness = 3'd3;
    cycles(FRAME_LEN);
    brightness = 3'd0;
    cycles(FRAME_LEN);

    brightness = 3'd7;
    blink_mask = 6'b000011;
    cycles(5 * FRAME_LEN);
    blink_mask = '0;

    // Mid-frame change including invalid codes
    wait_state(40);
    digit_bcd = 24'h00FA99;
    cycles(2 * FRAME_LEN);

    // One-cycle reset at digit 3, slot 9
    wait_state(3 * SLOT_LEN + 9);
    rst = 1'b1;
    cycles(1);
    rst = 1'b0;
    cycles(FRAME_LEN + 8);

    digit_bcd = 24'h000705;
    cycles(2 * FRAME_LEN);

    // Random traffic, changes land at arbitrary points in the frame
    repeat (40) begin
      cycles($urandom_range(1, 150));
      sh         = 4 * $urandom_range(0, 5);
      digit_bcd  = 24'($urandom) & (24'hFFFFFF >> sh);
      blink_mask = NUM_DIGITS'($urandom);
      brightness = PWM_BITS'($urandom);
      colon_in   = 1'($urandom);
    end
    cycles(2 * FRAME_LEN);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
